// File: rtl/bicubic_pkg.sv
// Shared constants and types for the bicubic multiplier arbitration slice.
// Holds the operand and product widths, the multiplier latency, and the
// owner-id type used to tag products travelling through the shared multiplier.
package bicubic_pkg;

  localparam int NUM_REQ = 4;
  localparam int A_W     = 10;
  localparam int B_W     = 18;
  localparam int P_W     = A_W + B_W;
  localparam int MUL_LAT = 4;
  localparam int ID_W    = $clog2(NUM_REQ);

  typedef logic [ID_W-1:0] ownerId_t;

endpackage

// File: rtl/bicubic_mul_pipe.sv
// Pipelined unsigned multiplier shared by the bicubic tap requesters.
// The full-width product of a_i and b_i emerges on prod_o exactly MUL_LAT
// clocks after the operands are presented. There is no enable, so the pipe
// always flows.
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset, clears the first stage only
//   a_i     operand A (pixel)
//   b_i     operand B (weight)
//   prod_o  a_i * b_i, MUL_LAT clocks later
module bicubic_mul_pipe #(
  parameter int A_W     = bicubic_pkg::A_W,
  parameter int B_W     = bicubic_pkg::B_W,
  parameter int MUL_LAT = bicubic_pkg::MUL_LAT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [A_W-1:0]       a_i,
  input  logic [B_W-1:0]       b_i,
  output logic [A_W+B_W-1:0]   prod_o
);

  import bicubic_pkg::*;

  localparam int PROD_W = A_W + B_W;

  logic [PROD_W-1:0] stage_q [MUL_LAT];

  // The product is formed at the input and then carried through the stage
  // registers. Only the first stage is reset; later stages need no reset
  // because the owner's tag pipeline decides whether a product is ever
  // reported.
  always_ff @(posedge clk_i) begin
    for (int s = MUL_LAT - 1; s > 0; s--) begin
      stage_q[s] <= stage_q[s-1];
    end
    if (rst_i) begin
      stage_q[0] <= '0;
    end else begin
      stage_q[0] <= PROD_W'(a_i) * PROD_W'(b_i);
    end
  end

  assign prod_o = stage_q[MUL_LAT-1];

endmodule

// File: rtl/bicubic_mul_arbiter.sv
// Round-robin arbiter in front of one shared pipelined multiplier.
// At most one requester is granted per clock. A tag pipeline that runs in
// parallel with the multiplier remembers who owns each product, so the
// product is returned to its owner MUL_LAT clocks after issue.
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   req_valid_i  per-requester operand valid
//   req_ready_o  per-requester grant, one-hot or zero
//   req_a_i      packed operand A, slice i belongs to requester i
//   req_b_i      packed operand B, slice i belongs to requester i
//   res_valid_o  one-hot result strobe
//   res_data_o   product, held between strobes
//   res_id_o     owner of res_data_o
//   busy_o       high while any product is in flight
//   inflight_o   number of products in flight
module bicubic_mul_arbiter #(
  parameter int NUM_REQ = bicubic_pkg::NUM_REQ,
  parameter int A_W     = bicubic_pkg::A_W,
  parameter int B_W     = bicubic_pkg::B_W,
  parameter int MUL_LAT = bicubic_pkg::MUL_LAT,
  parameter int ID_W    = bicubic_pkg::ID_W
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*A_W-1:0]       req_a_i,
  input  logic [NUM_REQ*B_W-1:0]       req_b_i,
  output logic [NUM_REQ-1:0]           res_valid_o,
  output logic [A_W+B_W-1:0]           res_data_o,
  output logic [ID_W-1:0]              res_id_o,
  output logic                         busy_o,
  output logic [$clog2(MUL_LAT+1)-1:0] inflight_o
);

  import bicubic_pkg::*;

  localparam int PROD_W = A_W + B_W;
  localparam int CNT_W  = $clog2(MUL_LAT + 1);

  logic [A_W-1:0]                opA [NUM_REQ];
  logic [B_W-1:0]                opB [NUM_REQ];
  logic [ID_W-1:0]               ptr_q, ptr_d;
  logic [ID_W-1:0]               scanIdx;
  logic [ID_W-1:0]               grantIdx;
  logic                          grantHit;
  logic                          transfer;
  logic                          retire;
  logic [PROD_W-1:0]             pipeProd;
  logic [MUL_LAT-1:0]            tagValid_q, tagValid_d;
  logic [MUL_LAT-1:0][ID_W-1:0]  tagId_q, tagId_d;
  logic [PROD_W-1:0]             resData_q, resData_d;
  logic [ID_W-1:0]               resId_q, resId_d;
  logic [CNT_W-1:0]              inflight_q, inflight_d;

  // Unpack the operand buses into per-requester arrays so that the winner
  // can be selected with a plain index.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign opA[g] = req_a_i[g*A_W +: A_W];
    assign opB[g] = req_b_i[g*B_W +: B_W];
  end

  // Round-robin search: start at the pointer, wrap around, and take the first
  // requester that is asserting valid.
  always_comb begin
    grantHit = 1'b0;
    grantIdx = '0;
    scanIdx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scanIdx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!grantHit && req_valid_i[scanIdx]) begin
        grantHit = 1'b1;
        grantIdx = scanIdx;
      end
    end
  end

  // A grant is only offered outside reset, so ready and transfer coincide.
  // The pointer moves just past the winner on a transfer and holds otherwise,
  // which keeps a requester that withdraws its valid from disturbing fairness.
  always_comb begin
    transfer    = grantHit && !rst_i;
    req_ready_o = transfer ? (NUM_REQ'(1) << grantIdx) : '0;
    ptr_d       = ptr_q;
    if (transfer) begin
      ptr_d = (int'(grantIdx) == NUM_REQ - 1) ? '0 : grantIdx + 1'b1;
    end
  end

  bicubic_mul_pipe #(
    .A_W     (A_W),
    .B_W     (B_W),
    .MUL_LAT (MUL_LAT)
  ) u_mul_pipe (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .a_i    (opA[grantIdx]),
    .b_i    (opB[grantIdx]),
    .prod_o (pipeProd)
  );

  // The tag pipeline shifts in lock-step with the multiplier stages. A product
  // is reported when its tag reaches the last stage; the strobe is masked
  // during reset so that products already in flight are silently discarded.
  // Data and owner are held between strobes, and the in-flight count only
  // moves when exactly one of issue and retire happens.
  always_comb begin
    tagValid_d[0] = transfer;
    tagId_d[0]    = grantIdx;
    for (int s = 1; s < MUL_LAT; s++) begin
      tagValid_d[s] = tagValid_q[s-1];
      tagId_d[s]    = tagId_q[s-1];
    end
    retire      = tagValid_q[MUL_LAT-1] && !rst_i;
    res_valid_o = retire ? (NUM_REQ'(1) << tagId_q[MUL_LAT-1]) : '0;
    resData_d   = retire ? pipeProd : resData_q;
    resId_d     = retire ? tagId_q[MUL_LAT-1] : resId_q;
    inflight_d  = inflight_q;
    if (transfer && !retire) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!transfer && retire) begin
      inflight_d = inflight_q - 1'b1;
    end
  end

  // All bookkeeping state is cleared by reset, including the pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      tagValid_q <= '0;
      tagId_q    <= '0;
      resData_q  <= '0;
      resId_q    <= '0;
      inflight_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      tagValid_q <= tagValid_d;
      tagId_q    <= tagId_d;
      resData_q  <= resData_d;
      resId_q    <= resId_d;
      inflight_q <= inflight_d;
    end
  end

  assign res_data_o = resData_d;
  assign res_id_o   = resId_d;
  assign inflight_o = inflight_q;
  assign busy_o     = (inflight_q != '0);

endmodule

// File: tb/tb_bicubic_mul_arbiter.sv
// Bench for the shared-multiplier arbiter. A driver applies directed and
// random requester activity; a monitor keeps a reference model of the
// round-robin grant, pushes each issued product into a scoreboard, and pops
// and compares whenever the design strobes a result.
module tb_bicubic_mul_arbiter;

  localparam int N   = 4;
  localparam int AW  = 10;
  localparam int BW  = 18;
  localparam int LAT = 4;
  localparam int IDW = 2;
  localparam int PW  = AW + BW;
  localparam int CW  = $clog2(LAT + 1);

  localparam int M_IDLE = 0;
  localparam int M_ALL  = 1;
  localparam int M_RAND = 2;
  localparam int M_ONE  = 3;
  localparam int M_HOLD = 4;
  localparam int M_PAIR = 5;

  typedef struct {
    int              id;
    longint unsigned data;
    int              due;
  } expEntry_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    reqValid;
  logic [N-1:0]    reqReady;
  logic [N*AW-1:0] reqA;
  logic [N*BW-1:0] reqB;
  logic [N-1:0]    resValid;
  logic [PW-1:0]   resData;
  logic [IDW-1:0]  resId;
  logic            busy;
  logic [CW-1:0]   inflight;

  expEntry_t       sbQ[$];
  int              errors = 0;
  int              checks = 0;
  int              cyc = 0;
  int              modelPtr = 0;
  longint unsigned lastData = 0;
  int              lastId = 0;
  int              waitCnt [N];

  logic [N-1:0]    pend;
  logic [AW-1:0]   curA [N];
  logic [BW-1:0]   curB [N];
  int              selReq;
  logic [AW-1:0]   selA;
  logic [BW-1:0]   selB;

  bicubic_mul_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (reqValid),
    .req_ready_o (reqReady),
    .req_a_i     (reqA),
    .req_b_i     (reqB),
    .res_valid_o (resValid),
    .res_data_o  (resData),
    .res_id_o    (resId),
    .busy_o      (busy),
    .inflight_o  (inflight)
  );

  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch on a single line.
  task automatic checkOutput(input string name, input longint unsigned actual,
                             input longint unsigned expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, actual, expected);
    end
  endtask

  // Copies the bench's requester state onto the design's input buses.
  task automatic driveBus();
    reqValid = pend;
    for (int i = 0; i < N; i++) begin
      reqA[i*AW +: AW] = curA[i];
      reqB[i*BW +: BW] = curB[i];
    end
  endtask

  function automatic logic [AW-1:0] randA();
    int pick = $urandom_range(0, 7);
    if (pick == 0) return '0;
    if (pick == 1) return '1;
    return AW'($urandom);
  endfunction

  function automatic logic [BW-1:0] randB();
    int pick = $urandom_range(0, 7);
    if (pick == 0) return '0;
    if (pick == 1) return '1;
    return BW'($urandom);
  endfunction

  // Runs n cycles of requester behaviour. Requesters keep valid and operands
  // steady until granted (except for the occasional random withdrawal).
  task automatic applyStimulus(input int mode, input int n);
    logic [N-1:0] granted;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      #1;
      granted = reqValid & reqReady;
      @(posedge clk);
      #1;
      pend = pend & ~granted;
      for (int i = 0; i < N; i++) begin
        case (mode)
          M_IDLE: pend[i] = 1'b0;
          M_ALL: if (!pend[i]) begin
            pend[i] = 1'b1;
            curA[i] = AW'(i + 1);
            curB[i] = BW'(10);
          end
          M_RAND: begin
            if (!pend[i]) begin
              if ($urandom_range(0, 2) == 0) begin
                pend[i] = 1'b1;
                curA[i] = randA();
                curB[i] = randB();
              end
            end else if ($urandom_range(0, 15) == 0) begin
              pend[i] = 1'b0;
            end
          end
          M_ONE: if (c == 0 && i == selReq) begin
            pend[i] = 1'b1;
            curA[i] = selA;
            curB[i] = selB;
          end
          M_HOLD: begin
            if (i != selReq) pend[i] = 1'b0;
            else if (!pend[i]) begin
              pend[i] = 1'b1;
              curA[i] = randA();
              curB[i] = randB();
            end
          end
          M_PAIR: begin
            if (i < 2) pend[i] = 1'b0;
            else if (!pend[i]) begin
              pend[i] = 1'b1;
              curA[i] = randA();
              curB[i] = randB();
            end
          end
          default: pend[i] = 1'b0;
        endcase
      end
      driveBus();
    end
  endtask

  task automatic pulseReset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    pend = '0;
    driveBus();
  endtask

  task automatic issueOne(input int idx, input logic [AW-1:0] a, input logic [BW-1:0] b);
    selReq = idx;
    selA   = a;
    selB   = b;
    applyStimulus(M_ONE, 1);
    applyStimulus(M_IDLE, LAT + 3);
  endtask

  // Monitor and reference model, evaluated mid-cycle. Grants are predicted
  // from the round-robin rule, each issued pair is queued with its due cycle,
  // and every strobe pops the oldest entry for comparison.
  always @(negedge clk) begin : monitor
    int              win;
    expEntry_t       e;
    longint unsigned expReady;
    cyc++;
    if (rst) begin
      checkOutput("rst_ready", reqReady, 0);
      checkOutput("rst_res_valid", resValid, 0);
      checkOutput("rst_res_data", resData, lastData);
      sbQ.delete();
      modelPtr = 0;
      lastData = 0;
      lastId   = 0;
      for (int i = 0; i < N; i++) waitCnt[i] = 0;
    end else begin
      checkOutput("inflight", inflight, sbQ.size());
      checkOutput("busy", busy, (sbQ.size() != 0) ? 1 : 0);

      if (resValid != '0) begin
        if (sbQ.size() == 0) begin
          checkOutput("res_spurious", resValid, 0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("res_cycle", cyc, e.due);
          checkOutput("res_valid", resValid, longint'(1) << e.id);
          checkOutput("res_data", resData, e.data);
          checkOutput("res_id", resId, e.id);
          lastData = e.data;
          lastId   = e.id;
        end
      end else begin
        if (sbQ.size() > 0 && sbQ[0].due <= cyc) begin
          e = sbQ.pop_front();
          checkOutput("res_missing", resValid, longint'(1) << e.id);
        end
        checkOutput("hold_data", resData, lastData);
        checkOutput("hold_id", resId, lastId);
      end

      win = -1;
      for (int k = 0; k < N; k++) begin
        if (win < 0 && reqValid[(modelPtr + k) % N]) win = (modelPtr + k) % N;
      end
      expReady = (win >= 0) ? (longint'(1) << win) : 0;
      checkOutput("ready", reqReady, expReady);
      if (win >= 0) begin
        e.id   = win;
        e.data = longint'(curA[win]) * longint'(curB[win]);
        e.due  = cyc + LAT;
        sbQ.push_back(e);
        modelPtr = (win + 1) % N;
      end

      for (int i = 0; i < N; i++) begin
        if (reqValid[i] && win != i) waitCnt[i]++;
        else waitCnt[i] = 0;
        if (reqValid[i]) checkOutput("fair_wait", (waitCnt[i] < N) ? 1 : 0, 1);
      end
    end
  end

  initial begin
    pend = '0;
    for (int i = 0; i < N; i++) begin
      curA[i] = '0;
      curB[i] = '0;
    end
    selReq = 0;
    selA   = '0;
    selB   = '0;
    driveBus();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(M_IDLE, 10);

    $display("[TB] single issue");
    issueOne(0, AW'(100), BW'(1000));
    checkOutput("single_data", resData, 100000);
    checkOutput("single_id", resId, 0);

    $display("[TB] full contention");
    applyStimulus(M_ALL, 12);
    applyStimulus(M_IDLE, LAT + 3);

    $display("[TB] single requester held");
    selReq = 1;
    applyStimulus(M_HOLD, 8);
    applyStimulus(M_IDLE, LAT + 3);

    $display("[TB] fairness between requesters 2 and 3");
    issueOne(2, AW'(7), BW'(9));
    checkOutput("pair_setup", resData, 63);
    applyStimulus(M_PAIR, 10);
    applyStimulus(M_IDLE, LAT + 3);

    $display("[TB] operand extremes");
    issueOne(3, AW'(1023), BW'(262143));
    checkOutput("extreme_data", resData, 268172289);
    checkOutput("extreme_id", resId, 3);
    issueOne(0, AW'(0), BW'(12345));
    checkOutput("zero_a", resData, 0);
    issueOne(1, AW'(777), BW'(0));
    checkOutput("zero_b", resData, 0);
    checkOutput("zero_b_id", resId, 1);

    $display("[TB] random traffic");
    applyStimulus(M_RAND, 300);
    applyStimulus(M_IDLE, LAT + 3);

    $display("[TB] reset mid-flight");
    applyStimulus(M_ALL, 3);
    pulseReset(2);
    applyStimulus(M_IDLE, LAT + 3);
    checkOutput("post_rst_data", resData, 0);
    applyStimulus(M_ALL, 4);
    applyStimulus(M_IDLE, LAT + 3);

    checkOutput("drain", sbQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
